// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, instruction
// field positions and the fetch FSM state encoding.
package busca_instrucao_pkg;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_COPY  = 3'd1;
   localparam logic [2:0] OP_READ  = 3'd2;
   localparam logic [2:0] OP_WRITE = 3'd3;
   localparam logic [2:0] OP_BEQZ  = 3'd4;
   localparam logic [2:0] OP_JUMP  = 3'd5;
   localparam logic [2:0] OP_ADDI  = 3'd6;
   localparam logic [2:0] OP_STOP  = 3'd7;

   localparam int INSTR_W    = 16;
   localparam int OPCODE_MSB = 15;
   localparam int OPCODE_LSB = 13;
   localparam int RA_MSB     = 12;
   localparam int RA_LSB     = 10;
   localparam int RB_MSB     = 9;
   localparam int RB_LSB     = 7;
   localparam int BV_MSB     = 6;
   localparam int BV_LSB     = 5;
   localparam int IMM_MSB    = 4;
   localparam int IMM_LSB    = 0;
   localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

   typedef enum logic [1:0] {
      BUSCA,
      DECODIFICA,
      EXECUTA,
      PARADO
   } estado_t;

endpackage

// File: rtl/busca_instrucao_proximo_pc.sv
// Combinational next-PC selection: STOP holds, jumps/taken branches add the
// sign-extended immediate, EscPC steps by one; arithmetic wraps at the PC width.
module proximo_pc
   import busca_instrucao_pkg::*;
#(
   parameter int LARGURA_PC = 8
) (
   input  logic [LARGURA_PC-1:0] i_pc,
   input  logic [IMM_W-1:0]      i_imm,
   input  logic                  i_stop,
   input  logic                  i_ji,
   input  logic                  i_beqz,
   input  logic                  i_zero,
   input  logic                  i_escpc,
   output logic [LARGURA_PC-1:0] o_proximo_pc
);

   logic [LARGURA_PC-1:0] w_imm_ext;

   assign w_imm_ext = {{(LARGURA_PC-IMM_W){i_imm[IMM_W-1]}}, i_imm};

   always_comb begin
      o_proximo_pc = i_pc;
      if (i_stop) begin
         o_proximo_pc = i_pc;
      end else if (i_ji || (i_beqz && i_zero)) begin
         o_proximo_pc = i_pc + w_imm_ext;
      end else if (i_escpc) begin
         o_proximo_pc = i_pc + LARGURA_PC'(1);
      end
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch/sequencing stage: fetch FSM, instruction register and PC.
// Optional executed-instruction counter enabled by defining BUSCA_CONTADOR_EN.
module busca_instrucao
   import busca_instrucao_pkg::*;
#(
   parameter int                    LARGURA_PC = 8,
   parameter logic [LARGURA_PC-1:0] PC_INICIAL = '0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   output logic                  mem_req,
   output logic [LARGURA_PC-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [INSTR_W-1:0]    mem_dado,
   output logic [2:0]            opcode,
   output logic [2:0]            ra,
   output logic [2:0]            rb,
   output logic [1:0]            BitVerificacao,
   output logic [IMM_W-1:0]      imm,
   output logic [LARGURA_PC-1:0] pc,
   output logic                  instr_valida,
   output logic                  parado,
   input  logic                  EscPC,
   input  logic                  Ji,
   input  logic                  Beqz,
   input  logic                  STOP,
   input  logic                  zero
`ifdef BUSCA_CONTADOR_EN
   ,
   output logic [15:0]           instr_contador
`endif
);

   estado_t               r_estado;
   logic [LARGURA_PC-1:0] r_pc;
   logic [INSTR_W-1:0]    r_ir;
   logic                  r_mem_req;
   logic                  r_instr_valida;
   logic                  r_parado;
   logic [LARGURA_PC-1:0] w_proximo_pc;

   proximo_pc #(
      .LARGURA_PC (LARGURA_PC)
   ) u_proximo_pc (
      .i_pc         (r_pc),
      .i_imm        (r_ir[IMM_MSB:IMM_LSB]),
      .i_stop       (STOP),
      .i_ji         (Ji),
      .i_beqz       (Beqz),
      .i_zero       (zero),
      .i_escpc      (EscPC),
      .o_proximo_pc (w_proximo_pc)
   );

   // Status outputs are registered alongside the state so that they never
   // depend combinationally on any input.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_estado       <= BUSCA;
         r_pc           <= PC_INICIAL;
         r_ir           <= '0;
         r_mem_req      <= 1'b1;
         r_instr_valida <= 1'b0;
         r_parado       <= 1'b0;
      end else begin
         case (r_estado)
            BUSCA: begin
               if (mem_ack) begin
                  r_ir      <= mem_dado;
                  r_mem_req <= 1'b0;
                  r_estado  <= DECODIFICA;
               end
            end
            DECODIFICA: begin
               r_instr_valida <= 1'b1;
               r_estado       <= EXECUTA;
            end
            EXECUTA: begin
               r_instr_valida <= 1'b0;
               r_pc           <= w_proximo_pc;
               if (STOP) begin
                  r_parado <= 1'b1;
                  r_estado <= PARADO;
               end else begin
                  r_mem_req <= 1'b1;
                  r_estado  <= BUSCA;
               end
            end
            PARADO: begin
               r_estado <= PARADO;
            end
            default: begin
               r_estado <= BUSCA;
            end
         endcase
      end
   end

`ifdef BUSCA_CONTADOR_EN
   logic [15:0] r_contador;

   // Counts every EXECUTA cycle, STOP included, and sticks at all-ones.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_contador <= '0;
      end else if ((r_estado == EXECUTA) && (r_contador != 16'hFFFF)) begin
         r_contador <= r_contador + 16'd1;
      end
   end

   assign instr_contador = r_contador;
`endif

   assign mem_req        = r_mem_req;
   assign mem_addr       = r_pc;
   assign pc             = r_pc;
   assign instr_valida   = r_instr_valida;
   assign parado         = r_parado;
   assign opcode         = r_ir[OPCODE_MSB:OPCODE_LSB];
   assign ra             = r_ir[RA_MSB:RA_LSB];
   assign rb             = r_ir[RB_MSB:RB_LSB];
   assign BitVerificacao = r_ir[BV_MSB:BV_LSB];
   assign imm            = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: a memory responder issues fetches from a
// per-address program table and queues expected executions checked by a monitor.
`timescale 1ns/1ps
module tb_busca_instrucao;

   logic        clock;
   logic        reset_n;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack;
   logic [15:0] mem_dado;
   logic [2:0]  opcode;
   logic [2:0]  ra;
   logic [2:0]  rb;
   logic [1:0]  BitVerificacao;
   logic [4:0]  imm;
   logic [7:0]  pc;
   logic        instr_valida;
   logic        parado;
   logic        EscPC;
   logic        Ji;
   logic        Beqz;
   logic        STOP;
   logic        zero;
`ifdef BUSCA_CONTADOR_EN
   logic [15:0] instr_contador;
`endif

   busca_instrucao #(
      .LARGURA_PC (8),
      .PC_INICIAL (8'h00)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_dado       (mem_dado),
      .opcode         (opcode),
      .ra             (ra),
      .rb             (rb),
      .BitVerificacao (BitVerificacao),
      .imm            (imm),
      .pc             (pc),
      .instr_valida   (instr_valida),
      .parado         (parado),
      .EscPC          (EscPC),
      .Ji             (Ji),
      .Beqz           (Beqz),
      .STOP           (STOP),
      .zero           (zero)
`ifdef BUSCA_CONTADOR_EN
      ,
      .instr_contador (instr_contador)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          pc;
      logic [15:0] word;
      int          cycle;
      bit          stop;
   } exp_t;

   exp_t        expQ[$];
   int          compared = 0;
   int          mismatched = 0;
   int          cycleNo = 0;
   int          execCount = 0;
   int          paradoFrom = 32'h7fffffff;
   int          stopPc = 0;

   logic [15:0] progWord [256];
   bit          progEsc  [256];
   bit          progJi   [256];
   bit          progBeqz [256];
   bit          progStop [256];
   bit          progZero [256];
   int          progWait [256];

   int          modelPc;
   bit          modelHalted;
   bit          inRequest;
   int          waitLeft;
   int          stallCycles;
   logic [15:0] lastWord;

   always @(posedge clock) cycleNo <= cycleNo + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Reference next-PC computed from the sequencing rules with plain integers.
   function automatic int refNext(input int curPc, input logic [15:0] w, input bit esc,
                                  input bit ji, input bit bq, input bit st, input bit z);
      int off;
      off = w[4] ? int'(w[4:0]) - 32 : int'(w[4:0]);
      if (st) return curPc;
      if (ji || (bq && z)) return (curPc + off + 256) % 256;
      if (esc) return (curPc + 1) % 256;
      return curPc;
   endfunction

   // Plays instruction memory and control unit for one cycle.
   task automatic applyStimulus();
      logic [15:0] w;
      if (modelHalted) begin
         mem_ack  = 1'($urandom);
         mem_dado = 16'($urandom);
         return;
      end
      if (!mem_req) begin
         if (inRequest) checkOutput("reqHeld", mem_req, 1);
         mem_ack  = 1'($urandom);
         mem_dado = 16'($urandom);
         return;
      end
      checkOutput(inRequest ? "stallAddr" : "fetchAddr", mem_addr, modelPc);
      checkOutput("irHeld", {opcode, ra, rb, BitVerificacao, imm}, lastWord);
      if (!inRequest) begin
         inRequest   = 1'b1;
         waitLeft    = progWait[modelPc];
         stallCycles = 0;
      end
      if (waitLeft > 0) begin
         waitLeft--;
         stallCycles++;
         mem_ack  = 1'b0;
         mem_dado = 16'($urandom);
      end else begin
         w        = progWord[modelPc];
         mem_ack  = 1'b1;
         mem_dado = w;
         EscPC    = progEsc[modelPc];
         Ji       = progJi[modelPc];
         Beqz     = progBeqz[modelPc];
         STOP     = progStop[modelPc];
         zero     = progZero[modelPc];
         expQ.push_back('{modelPc, w, cycleNo + 2, progStop[modelPc]});
         lastWord = w;
         if (progStop[modelPc]) modelHalted = 1'b1;
         modelPc = refNext(modelPc, w, progEsc[modelPc], progJi[modelPc],
                           progBeqz[modelPc], progStop[modelPc], progZero[modelPc]);
         inRequest = 1'b0;
      end
   endtask

   always @(negedge clock) begin
      if (!reset_n) begin
         expQ.delete();
         execCount  = 0;
         paradoFrom = 32'h7fffffff;
      end else begin
`ifdef BUSCA_CONTADOR_EN
         checkOutput("counter", instr_contador, (execCount > 65535) ? 65535 : execCount);
`endif
         if (expQ.size() > 0 && expQ[0].cycle == cycleNo) begin
            exp_t r;
            r = expQ.pop_front();
            checkOutput("validPulse", instr_valida, 1);
            checkOutput("execPc", pc, r.pc);
            checkOutput("fields", {opcode, ra, rb, BitVerificacao, imm}, r.word);
            execCount++;
            if (r.stop) begin
               paradoFrom = cycleNo + 1;
               stopPc     = r.pc;
            end
         end else begin
            checkOutput("validIdle", instr_valida, 0);
         end
         if (cycleNo >= paradoFrom) begin
            checkOutput("parado", parado, 1);
            checkOutput("haltReq", mem_req, 0);
            checkOutput("haltPc", pc, stopPc);
         end else begin
            checkOutput("notParado", parado, 0);
         end
      end
   end

   task automatic loadDefault();
      for (int i = 0; i < 256; i++) begin
         progWord[i] = 16'h0000;
         progEsc[i]  = 1'b1;
         progJi[i]   = 1'b0;
         progBeqz[i] = 1'b0;
         progStop[i] = 1'b0;
         progZero[i] = 1'b0;
         progWait[i] = 0;
      end
   endtask

   task automatic loadRandom();
      for (int i = 0; i < 256; i++) begin
         progWord[i] = 16'($urandom);
         progEsc[i]  = ($urandom % 4) != 0;
         progJi[i]   = ($urandom % 6) == 0;
         progBeqz[i] = ($urandom % 4) == 0;
         progStop[i] = ($urandom % 24) == 0;
         progZero[i] = 1'($urandom);
         progWait[i] = $urandom_range(0, 3);
      end
   endtask

   task automatic setInstr(input int a, input logic [2:0] op, input logic [4:0] im,
                           input bit esc, input bit ji, input bit bq, input bit st, input bit z);
      progWord[a] = {op, 3'($urandom), 3'($urandom), 2'($urandom), im};
      progEsc[a]  = esc;
      progJi[a]   = ji;
      progBeqz[a] = bq;
      progStop[a] = st;
      progZero[a] = z;
   endtask

   // Asserts reset away from a clock edge, checks the asynchronous effect, then releases.
   task automatic doReset();
      @(negedge clock);
      reset_n  = 1'b0;
      mem_ack  = 1'b0;
      mem_dado = 16'h0000;
      {EscPC, Ji, Beqz, STOP, zero} = 5'b0;
      #1;
      checkOutput("rstPc", pc, 0);
      checkOutput("rstAddr", mem_addr, 0);
      checkOutput("rstReq", mem_req, 1);
      checkOutput("rstIr", {opcode, ra, rb, BitVerificacao, imm}, 0);
      checkOutput("rstValid", instr_valida, 0);
      checkOutput("rstParado", parado, 0);
`ifdef BUSCA_CONTADOR_EN
      checkOutput("rstCounter", instr_contador, 0);
`endif
      modelPc     = 0;
      modelHalted = 1'b0;
      inRequest   = 1'b0;
      waitLeft    = 0;
      stallCycles = 0;
      lastWord    = 16'h0000;
      @(posedge clock);
      @(negedge clock);
      #2 reset_n = 1'b1;
   endtask

   task automatic runScenario(input int maxInstr, input bit expectHalt);
      int extra;
      extra = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         applyStimulus();
         if (modelHalted) extra++;
         if (extra > 8 || execCount >= maxInstr) break;
      end
      if (expectHalt) checkOutput("haltReached", parado, 1);
   endtask

   initial begin
      reset_n  = 1'b0;
      mem_ack  = 1'b0;
      mem_dado = 16'h0000;
      {EscPC, Ji, Beqz, STOP, zero} = 5'b0;

      loadDefault();
      doReset();
      runScenario(12, 1'b0);

      loadDefault();
      progWait[3] = 4;
      setInstr(9, 3'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      doReset();
      runScenario(100, 1'b1);
`ifdef BUSCA_CONTADOR_EN
      checkOutput("counterAtStop", instr_contador, 10);
`endif

      loadDefault();
      setInstr(0,     3'd5, 5'd15,     1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      setInstr(8'h10, 3'd5, 5'b11110,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      setInstr(8'h0E, 3'd7, 5'd0,      1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      doReset();
      runScenario(100, 1'b1);

      loadDefault();
      setInstr(0, 3'd5, 5'b11111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      doReset();
      runScenario(6, 1'b0);

      for (int z = 0; z < 2; z++) begin
         loadDefault();
         setInstr(4, 3'd4, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, z == 0);
         setInstr(z == 0 ? 7 : 5, 3'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         doReset();
         runScenario(100, 1'b1);
      end

      loadDefault();
      setInstr(0, 3'd5, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      progWait[6] = 40;
      doReset();
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         applyStimulus();
         if (modelPc == 6 && inRequest && stallCycles >= 2) break;
      end
      checkOutput("stallPc", pc, 6);
      progWait[6] = 0;
      setInstr(6, 3'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      doReset();
      runScenario(100, 1'b1);

      for (int s = 0; s < 6; s++) begin
         loadRandom();
         doReset();
         runScenario(60, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch and sequencing stage sitting directly upstream of the control unit. It fetches 16-bit instructions from instruction memory over a request/acknowledge handshake and splits them into fields, presenting `opcode` and `BitVerificacao` to the control unit. It then consumes the registered control outputs (`EscPC`, `Ji`, `Beqz`, `STOP`) together with the ULA zero flag to compute the next PC. It also owns the halted state of the processor.

## Interface
- `LARGURA_PC`, 8: PC and instruction-address width.
- `PC_INICIAL`, 0: PC value loaded on reset.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `mem_req`  out  1: instruction-memory read request.
- `mem_addr`  out  LARGURA_PC: read address; always equals `pc`.
- `mem_ack`  in  1: read data valid this cycle.
- `mem_dado`  in  16: instruction word.
- `opcode`  out  3: instruction [15:13], to the control unit.
- `ra`, `rb`  out  3 each: instruction [12:10] and [9:7].
- `BitVerificacao`  out  2: instruction [6:5], to the control unit.
- `imm`  out  5: instruction [4:0].
- `pc`  out  LARGURA_PC: current PC.
- `instr_valida`  out  1: high for the one EXECUTA cycle of each instruction.
- `parado`  out  1: processor halted.
- `EscPC`, `Ji`, `Beqz`, `STOP`  in  1 each: registered control-unit outputs.
- `zero`  in  1: ULA result equals zero; sampled in EXECUTA.

## Operation
- FSM states:
  - BUSCA: `mem_req`=1; on `mem_ack`, load IR from `mem_dado` and go to DECODIFICA.
  - DECODIFICA: IR fields are driven out; the control unit registers its outputs at the end of this cycle. Go to EXECUTA.
  - EXECUTA: `instr_valida`=1; update PC, then go to BUSCA, or to PARADO when `STOP`=1.
  - PARADO: terminal state; `parado`=1; exits only on reset.
- Next-PC priority, evaluated in EXECUTA only:
  1. `STOP` → hold PC.
  2. `Ji` → pc + sext(`imm`).
  3. `Beqz` && `zero` → pc + sext(`imm`).
  4. `EscPC` → pc + 1.
  5. Otherwise → hold PC.
- Sign-extend `imm` from 5 bits to LARGURA_PC. All PC arithmetic is modulo 2^LARGURA_PC (wraps silently).
- `Beqz`=1 with `zero`=0 falls through to pc+1, because the control unit always asserts `EscPC` alongside `Beqz`.
- `mem_ack` is ignored whenever `mem_req`=0.
- IR fields hold their value from the end of BUSCA until the next successful fetch.

## Timing
- Reset values: state=BUSCA, `pc`=PC_INICIAL, IR=0 (so `opcode`=0, `ra`=`rb`=0, `BitVerificacao`=0, `imm`=0). `instr_valida`=0, `parado`=0. `mem_req`=1 combinationally from state after reset release.
- Reset asserted mid-operation (including during an outstanding request) takes effect asynchronously. `mem_req` must not hold 1 from the previous request: it is re-driven as a fresh request at PC_INICIAL.
- Zero-wait memory (`mem_ack` in the same cycle as `mem_req`) gives the minimum of 3 cycles per instruction. Each wait cycle adds 1. `mem_addr` and `mem_req` stay stable until ack.
- The PC update is visible the cycle after EXECUTA, coincident with the next BUSCA.
- `mem_req`, `instr_valida` and `parado` are decoded from state with no combinational path from inputs.

## Configuration
- `BUSCA_CONTADOR_EN` defined: adds output `instr_contador` (16 bits).
  - Reset value 0.
  - Increments once per EXECUTA cycle, including the STOP instruction.
  - Saturates at 16'hFFFF.
- `BUSCA_CONTADOR_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - opcode constants (ADD=0, COPY=1, READ=2, WRITE=3, BEQZ=4, JUMP=5, ADDI=6, STOP=7);
  - instruction field bit positions;
  - the FSM state enum (BUSCA, DECODIFICA, EXECUTA, PARADO).
- One sub-module, `proximo_pc`: combinational next-PC selection and sign extension, taking pc, imm, STOP, Ji, Beqz, zero and EscPC.
- The FSM, IR and counter live in the top module.

## Test plan
- Reset release with PC_INICIAL=0 and zero-wait ack of `mem_dado`=16'h0000 (ADD), control inputs `EscPC`=1: `mem_addr` sequence 0,1,2 with fetches 3 cycles apart; `instr_valida` pulses once per instruction.
- `mem_ack` delayed 4 cycles: `mem_req`=1 and `mem_addr` held stable for 5 cycles; the IR does not change before ack.
- JUMP at pc=8'h10 with `imm`=5'b11110 (−2): next `mem_addr`=8'h0E. At pc=8'hFF with `EscPC`=1, next `mem_addr`=8'h00 (wrap).
- BEQZ at pc=4 with `imm`=3:
  - `zero`=1: next pc=7.
  - `zero`=0: next pc=5.
- STOP at pc=9: `parado`=1 from the next cycle, `mem_req` stays 0 and pc stays 9 indefinitely. With `BUSCA_CONTADOR_EN`, `instr_contador` = number of executed instructions including STOP.
- `reset_n` pulsed low during a stalled BUSCA at pc=6: all outputs return to reset values immediately, then fetch restarts at PC_INICIAL.
